// File: rtl/fp16_tpu_pkg.sv
// Shared types and constants for the FP16 systolic-array operand path.
// Holds the feeder state encoding and a helper that extracts one FP16 lane from a packed vector.
package fp16_tpu_pkg;
   localparam int FP16_W = 16;
   localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
   localparam int ARR_SIZE = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } feed_state_e;

   function automatic logic [FP16_W-1:0] lane_slice(
      input logic [ARR_SIZE*FP16_W-1:0] vec,
      input logic [$clog2(ARR_SIZE)-1:0] lane
   );
      return vec[{lane, 4'h0} +: FP16_W];
   endfunction
endpackage

// File: rtl/fp16_feed_lane_sel.sv
// Picks the FP16 word one array lane should see at stream step n.
// A lane is skewed by its own index and carries data only while its slice window is open.
module fp16_feed_lane_sel
   import fp16_tpu_pkg::*;
#(
   parameter int K_MAX  = 8,
   parameter int N_W    = 5,
   parameter int CNT_W  = 4,
   parameter int LANE_W = 3,
   localparam int IDX_W = (K_MAX > 1) ? $clog2(K_MAX) : 1
) (
   input  logic [FP16_W-1:0] col [K_MAX],
   input  logic [N_W-1:0]    n,
   input  logic [LANE_W-1:0] lane,
   input  logic [CNT_W-1:0]  k_len,
   output logic [FP16_W-1:0] word
);
   logic [N_W-1:0] d;

   always_comb begin
      d    = n - N_W'(lane);
      word = FP16_ZERO;
      // k_len never exceeds K_MAX, so the low index bits are enough once d < k_len.
      if ((n >= N_W'(lane)) && (d < N_W'(k_len)))
         word = col[d[IDX_W-1:0]];
   end
endmodule

// File: rtl/fp16_systolic_feeder.sv
// Operand-edge feeder for the 8x8 FP16 systolic array: buffers k-slices, then clears and streams them skewed.
// Defining FEEDER_PERF_CNT_EN adds the perf_runs / perf_stall counters and ports.
//  state  | meaning
//  IDLE   | accepting slices, waiting for a valid start
//  CLEAR  | one-cycle accumulator clear, array disabled
//  STREAM | skewed operands driven, array enabled
//  DONE   | one-cycle done pulse, buffer consumed
module fp16_systolic_feeder
   import fp16_tpu_pkg::*;
#(
   parameter int SIZE   = ARR_SIZE,
   parameter int K_MAX  = 8,
   parameter int PE_LAT = 2,
   localparam int CNT_W = $clog2(K_MAX + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SIZE*FP16_W-1:0] in_a,
   input  logic [SIZE*FP16_W-1:0] in_w,
   input  logic                   start,
   input  logic [CNT_W-1:0]       k_len,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   arr_enable,
   output logic                   arr_acc_clear,
   output logic [SIZE*FP16_W-1:0] arr_a,
   output logic [SIZE*FP16_W-1:0] arr_w
`ifdef FEEDER_PERF_CNT_EN
   ,
   output logic [31:0]            perf_runs,
   output logic [31:0]            perf_stall
`endif
);
   localparam int IDX_W  = (K_MAX > 1) ? $clog2(K_MAX) : 1;
   localparam int LANE_W = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int TAIL   = 2*(SIZE-1) + PE_LAT - 1;
   localparam int N_W    = $clog2(K_MAX + TAIL + 1);
   localparam logic [CNT_W-1:0] K_FULL = CNT_W'(K_MAX);

   feed_state_e state, state_nx;
   logic [CNT_W-1:0] count, count_nx, kl, kl_nx;
   logic [N_W-1:0]   n, n_nx, remain, remain_nx;
   logic             accept, err_nx;
   logic [FP16_W-1:0] buf_a [SIZE][K_MAX];
   logic [FP16_W-1:0] buf_w [SIZE][K_MAX];
   logic [SIZE*FP16_W-1:0] sel_a, sel_w;

   assign accept = in_valid & in_ready;

   always_comb begin
      state_nx  = state;
      count_nx  = count + {{(CNT_W-1){1'b0}}, accept};
      kl_nx     = kl;
      n_nx      = n;
      remain_nx = remain;
      err_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if ((k_len == '0) || (k_len > count_nx)) begin
                  err_nx = 1'b1;
               end else begin
                  state_nx = CLEAR;
                  kl_nx    = k_len;
               end
            end
         end
         CLEAR: begin
            state_nx  = STREAM;
            n_nx      = '0;
            // STREAM lasts k_len + TAIL + 1 cycles; remain counts down to the last one.
            remain_nx = N_W'(kl) + N_W'(TAIL);
         end
         STREAM: begin
            if (remain == '0) begin
               state_nx = DONE;
               count_nx = '0;
            end else begin
               n_nx      = n + 1'b1;
               remain_nx = remain - 1'b1;
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < SIZE; r++) begin
            buf_a[r][count[IDX_W-1:0]] <= lane_slice(in_a, LANE_W'(r));
            buf_w[r][count[IDX_W-1:0]] <= lane_slice(in_w, LANE_W'(r));
         end
      end
   end

   for (genvar r = 0; r < SIZE; r++) begin : g_lane
      fp16_feed_lane_sel #(.K_MAX(K_MAX), .N_W(N_W), .CNT_W(CNT_W), .LANE_W(LANE_W)) u_sel_a (
         .col(buf_a[r]), .n(n_nx), .lane(LANE_W'(r)), .k_len(kl_nx),
         .word(sel_a[r*FP16_W +: FP16_W])
      );
      fp16_feed_lane_sel #(.K_MAX(K_MAX), .N_W(N_W), .CNT_W(CNT_W), .LANE_W(LANE_W)) u_sel_w (
         .col(buf_w[r]), .n(n_nx), .lane(LANE_W'(r)), .k_len(kl_nx),
         .word(sel_w[r*FP16_W +: FP16_W])
      );
   end

   // Outputs are registered from next-state values so each phase is visible in the cycle it names.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         count         <= '0;
         kl            <= '0;
         n             <= '0;
         remain        <= '0;
         in_ready      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         arr_enable    <= 1'b0;
         arr_acc_clear <= 1'b0;
         arr_a         <= '0;
         arr_w         <= '0;
      end else begin
         state         <= state_nx;
         count         <= count_nx;
         kl            <= kl_nx;
         n             <= n_nx;
         remain        <= remain_nx;
         in_ready      <= (state_nx == IDLE) && (count_nx < K_FULL);
         busy          <= (state_nx != IDLE);
         done          <= (state_nx == DONE);
         err           <= err_nx;
         arr_enable    <= (state_nx == STREAM);
         arr_acc_clear <= (state_nx == CLEAR);
         arr_a         <= (state_nx == STREAM) ? sel_a : '0;
         arr_w         <= (state_nx == STREAM) ? sel_w : '0;
      end
   end

`ifdef FEEDER_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_runs  <= '0;
         perf_stall <= '0;
      end else begin
         if (state_nx == DONE)
            perf_runs <= perf_runs + 32'd1;
         if (in_valid && !in_ready)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fp16_systolic_feeder.sv
// Randomized bench for fp16_systolic_feeder against a queue-based model of the slice buffer.
// Expected array lanes come straight from the skew/window rule applied to the loaded slices.
module tb_fp16_systolic_feeder;
   import fp16_tpu_pkg::*;

   localparam int SIZE   = 8;
   localparam int K_MAX  = 8;
   localparam int PE_LAT = 2;
   localparam int VW     = SIZE*16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    k_len = '0;
   logic [VW-1:0] in_a = '0;
   logic [VW-1:0] in_w = '0;
   logic          in_ready, busy, done, err, arr_enable, arr_acc_clear;
   logic [VW-1:0] arr_a, arr_w;
`ifdef FEEDER_PERF_CNT_EN
   logic [31:0]   perf_runs, perf_stall;
`endif

   int total = 0;
   int bad   = 0;
   logic [VW-1:0] qa[$];
   logic [VW-1:0] qw[$];

   always #5 clk = ~clk;

   fp16_systolic_feeder dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w),
      .start(start), .k_len(k_len),
      .busy(busy), .done(done), .err(err),
      .arr_enable(arr_enable), .arr_acc_clear(arr_acc_clear),
      .arr_a(arr_a), .arr_w(arr_w)
`ifdef FEEDER_PERF_CNT_EN
      , .perf_runs(perf_runs), .perf_stall(perf_stall)
`endif
   );

   task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < VW/32; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   // Lane r at step n carries slice n-r of its own lane while 0 <= n-r < k.
   function automatic logic [VW-1:0] expect_lanes(input bit is_w, input int n, input int k);
      logic [VW-1:0] v;
      logic [VW-1:0] s;
      v = '0;
      for (int r = 0; r < SIZE; r++) begin
         if ((n - r >= 0) && (n - r < k)) begin
            s = is_w ? qw[n-r] : qa[n-r];
            v[16*r +: 16] = s[16*r +: 16];
         end
      end
      return v;
   endfunction

   task automatic load(input int cnt, input bit fixed, input logic [VW-1:0] fv);
      for (int i = 0; i < cnt; i++) begin
         in_a     = fixed ? fv : rand_vec();
         in_w     = fixed ? fv : rand_vec();
         in_valid = 1'b1;
         chk("load_rdy", VW'(in_ready), VW'(1'b1));
         if (in_ready) begin
            qa.push_back(in_a);
            qw.push_back(in_w);
         end
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic bad_start(input int k);
      bit room;
      start = 1'b1;
      k_len = 4'(k);
      step();
      start = 1'b0;
      chk("err_pulse", VW'({err, busy, arr_acc_clear}), VW'(3'b100));
      step();
      room = (qa.size() < K_MAX);
      chk("err_after", VW'({err, busy, in_ready}), VW'({2'b00, room}));
   endtask

   task automatic run(input int k, input bit with_slice, output int nz7_first, output int nz7_cnt);
      int last;
      last      = k + 2*(SIZE-1) + PE_LAT - 1;
      nz7_first = -1;
      nz7_cnt   = 0;
      if (with_slice) begin
         in_a     = rand_vec();
         in_w     = rand_vec();
         in_valid = 1'b1;
         chk("join_rdy", VW'(in_ready), VW'(1'b1));
         if (in_ready) begin
            qa.push_back(in_a);
            qw.push_back(in_w);
         end
      end
      start = 1'b1;
      k_len = 4'(k);
      step();
      start    = 1'b0;
      in_valid = 1'b0;
      chk("clr_ctl", VW'({arr_acc_clear, arr_enable, busy, done, err, in_ready}), VW'(6'b101000));
      chk("clr_ops", arr_a | arr_w, '0);
      for (int n = 0; n <= last; n++) begin
         start    = 1'($urandom_range(0, 1));
         k_len    = 4'($urandom_range(0, 8));
         in_valid = 1'($urandom_range(0, 1));
         in_a     = rand_vec();
         in_w     = rand_vec();
         step();
         chk("str_ctl", VW'({arr_acc_clear, arr_enable, busy, done, err, in_ready}), VW'(6'b011000));
         chk("str_a", arr_a, expect_lanes(1'b0, n, k));
         chk("str_w", arr_w, expect_lanes(1'b1, n, k));
         if (arr_a[VW-1 -: 16] != 16'h0000) begin
            if (nz7_first < 0) nz7_first = n;
            nz7_cnt++;
         end
      end
      start    = 1'b0;
      in_valid = 1'b0;
      step();
      chk("done_ctl", VW'({arr_acc_clear, arr_enable, busy, done, err, in_ready}), VW'(6'b001100));
      chk("done_ops", arr_a | arr_w, '0);
      step();
      chk("idle_ctl", VW'({arr_acc_clear, arr_enable, busy, done, err, in_ready}), VW'(6'b000001));
      qa.delete();
      qw.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int f7, c7, acc, cnt, k;
      logic [VW-1:0] v;

      // Reset held with inputs active: nothing may respond.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      start    = 1'b1;
      k_len    = 4'd3;
      in_a     = rand_vec();
      in_w     = rand_vec();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_ctl", VW'({in_ready, busy, done, err, arr_enable, arr_acc_clear}), '0);
         chk("rst_ops", arr_a | arr_w, '0);
      end
      in_valid = 1'b0;
      start    = 1'b0;
      rst_n    = 1'b1;
      step();
      chk("post_rst", VW'({in_ready, busy, done, err}), VW'(4'b1000));

      // Identity run with 1.0 everywhere.
      load(8, 1'b1, {8{16'h3C00}});
      run(8, 1'b0, f7, c7);
      chk("id_nz7_first", VW'(f7), VW'(7));
      chk("id_nz7_cnt", VW'(c7), VW'(8));

      // Skew: single slice with distinct per-lane values.
      for (int r = 0; r < SIZE; r++) v[16*r +: 16] = 16'h4000 + 16'(r);
      load(1, 1'b1, v);
      run(1, 1'b0, f7, c7);
      chk("skew_nz7_first", VW'(f7), VW'(7));
      chk("skew_nz7_cnt", VW'(c7), VW'(1));

      // Backpressure: ten offered back-to-back, buffer holds eight.
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         in_a     = rand_vec();
         in_w     = rand_vec();
         in_valid = 1'b1;
         if (in_ready) begin
            qa.push_back(in_a);
            qw.push_back(in_w);
            acc++;
         end
         step();
      end
      in_valid = 1'b0;
      chk("bp_accepted", VW'(acc), VW'(8));
      chk("bp_ready_low", VW'(in_ready), VW'(1'b0));
      run(3, 1'b0, f7, c7);

      // Bad starts keep the buffer; then a start joined by a fifth slice.
      load(4, 1'b0, '0);
      bad_start(0);
      bad_start(5);
      run(5, 1'b1, f7, c7);

      // Random loads and lengths, including payloads that look like NaN/Inf/-0.
      for (int it = 0; it < 6; it++) begin
         cnt = $urandom_range(1, K_MAX);
         load(cnt, 1'b0, '0);
         k = $urandom_range(1, cnt);
         run(k, 1'b0, f7, c7);
      end
      load(2, 1'b1, {16'h7E00, 16'h7C00, 16'h8000, 16'hFC00, 16'h7E01, 16'h0001, 16'h8000, 16'h7BFF});
      run(2, 1'b0, f7, c7);

      // Abort mid-stream at n=5.
      load(8, 1'b0, '0);
      start = 1'b1;
      k_len = 4'd8;
      step();
      start = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("abort_en", VW'(arr_enable), VW'(1'b1));
      rst_n = 1'b0;
      step();
      chk("abort_ctl", VW'({in_ready, busy, done, err, arr_enable, arr_acc_clear}), '0);
      chk("abort_ops", arr_a | arr_w, '0);
      rst_n = 1'b1;
      step();
      chk("abort_post", VW'({done, busy, err, in_ready}), VW'(4'b0001));
      qa.delete();
      qw.delete();
      bad_start(1);
      load(8, 1'b0, '0);
      run(8, 1'b0, f7, c7);
      chk("abort_rerun_nz7", VW'(c7), VW'(8));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
